wb_region_fabric: RTL and testbench

//  Parametrised Wishbone B3 slave-side interconnect that replaces hand-written region decode and ack/data OR-trees.

---
 rtl/wb_region_fabric_if.sv | 24 ++
 rtl/wb_region_fabric.sv | 101 ++++++++++
 tb/tb_wb_region_fabric.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_region_fabric_if.sv
// wb_region_fabric_if: Wishbone master-side and slave-side signals of the region fabric
interface wb_region_fabric_if #(
    parameter int NSLV = 4,
    parameter int AW   = 64,
    parameter int DW   = 16
);
    logic [AW-1:0]      m_adr_i;
    logic               m_cyc_i;
    logic               m_stb_i;
    logic [DW-1:0]      m_dat_o;
    logic               m_ack_o;
    logic               m_err_o;
    logic [NSLV-1:0]    s_stb_o;
    logic [NSLV-1:0]    s_ack_i;
    logic [NSLV*DW-1:0] s_dat_i;
    modport master (
        output m_adr_i, m_cyc_i, m_stb_i, s_ack_i, s_dat_i,
        input  m_dat_o, m_ack_o, m_err_o, s_stb_o
    );
    modport slave (
        input  m_adr_i, m_cyc_i, m_stb_i, s_ack_i, s_dat_i,
        output m_dat_o, m_ack_o, m_err_o, s_stb_o
    );
endinterface

// File: rtl/wb_region_fabric.sv
// wb_region_fabric: region decode, ack/data mux and bus timeout for one Wishbone master.
// Define WB_FABRIC_ERR_EN to terminate holes/timeouts with ERR instead of a zero-data ACK.
module wb_region_fabric #(
    parameter int                 NSLV = 4,
    parameter int                 AW   = 64,
    parameter int                 DW   = 16,
    parameter int                 RLSB = 20,
    parameter int                 RW   = 4,
    parameter logic [NSLV*RW-1:0] RMAP = {4'hF, 4'h2, 4'h1, 4'h0},
    parameter int                 TMO  = 255
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    wb_region_fabric_if.slave bus,
    output logic              fault_o,
    output logic [RW-1:0]     fault_reg_o
);
    localparam int IW = NSLV > 1 ? $clog2(NSLV) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;
    state_t          state, state_d;
    logic [15:0]     cnt, cnt_d;
    logic [IW-1:0]   idx, idx_d, hit_idx;
    logic [RW-1:0]   region, freg_d;
    logic            hit, req, ack, err, fault;
    logic [NSLV-1:0] stb;
    logic [DW-1:0]   dat;
    logic            unused_adr;
    assign region     = bus.m_adr_i[RLSB+:RW];
    assign req        = bus.m_cyc_i & bus.m_stb_i;
    assign unused_adr = ^bus.m_adr_i;
    // Scan downward so the lowest matching slot is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (region == RMAP[k*RW+:RW]) begin
                hit     = 1'b1;
                hit_idx = IW'(k);
            end
        end
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            fault_reg_o <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            fault_reg_o <= freg_d;
        end
    end
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        freg_d  = fault_reg_o;
        stb     = '0;
        ack     = 1'b0;
        err     = 1'b0;
        dat     = '0;
        fault   = 1'b0;
        case (state)
            IDLE: if (req) begin
                cnt_d   = '0;
                idx_d   = hit_idx;
                state_d = hit ? WAIT : TERM;
                freg_d  = hit ? fault_reg_o : region;
            end
            WAIT: begin
                stb[idx] = req;
                if (!req) state_d = IDLE;
                else if (bus.s_ack_i[idx]) begin
                    ack     = 1'b1;
                    dat     = bus.s_dat_i[idx*DW+:DW];
                    state_d = IDLE;
                end else if (cnt == 16'(TMO - 1)) begin
                    state_d = TERM;
                    freg_d  = region;
                end else cnt_d = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
            end
            TERM: begin
                fault   = 1'b1;
                state_d = IDLE;
`ifdef WB_FABRIC_ERR_EN
                err     = 1'b1;
`else
                ack     = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.s_stb_o = stb;
    assign bus.m_ack_o = ack;
    assign bus.m_err_o = err;
    assign bus.m_dat_o = dat;
    assign fault_o     = fault;
endmodule

// File: tb/tb_wb_region_fabric.sv
// tb_wb_region_fabric: table-driven scoreboard bench for wb_region_fabric with TMO=8
module tb_wb_region_fabric;
    localparam int NSLV = 4, AW = 64, DW = 16, RW = 4, TMO = 8;
`ifdef WB_FABRIC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    typedef struct {
        logic [15:0] dat;
        logic [3:0]  stb;
        int          stbn;
        int          lat;
        logic        fault;
        logic [3:0]  rg;
    } exp_t;
    typedef struct {
        logic [63:0] adr;
        logic [3:0]  spur;
        exp_t        e;
    } vec_t;

    logic clk_i = 1'b0;
    logic reset_ni = 1'b0;
    logic fault_o;
    logic [RW-1:0] fault_reg_o;
    wb_region_fabric_if #(.NSLV(NSLV), .AW(AW), .DW(DW)) bus ();
    wb_region_fabric #(.NSLV(NSLV), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .bus(bus), .fault_o(fault_o), .fault_reg_o(fault_reg_o)
    );
    always #5 clk_i = ~clk_i;

    // Slave models: slave k acks once its strobe has been high lat[k] earlier cycles
    int lat [NSLV] = '{1, 1000, 0, 2};
    logic [DW-1:0] sdat [NSLV] = '{16'hBEEF, 16'h1111, 16'h2222, 16'h3333};
    int scnt [NSLV];
    logic [NSLV-1:0] spur, sack;
    logic [NSLV*DW-1:0] sd;
    always @(posedge clk_i)
        for (int k = 0; k < NSLV; k++) scnt[k] <= bus.s_stb_o[k] ? scnt[k] + 1 : 0;
    always_comb begin
        sack = '0;
        sd   = '0;
        for (int k = 0; k < NSLV; k++) begin
            sack[k]        = bus.s_stb_o[k] && scnt[k] == lat[k];
            sd[k*DW+:DW]   = sdat[k];
        end
    end
    assign bus.s_ack_i = sack | spur;
    assign bus.s_dat_i = sd;

    exp_t q[$];
    int start, stb_n, samp, checks, errors;
    logic [3:0] stb_or;

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        samp++;
        if (q.size() != 0) begin
            stb_or |= bus.s_stb_o;
            stb_n  += (bus.s_stb_o != 0) ? 1 : 0;
        end
        chk("invariant", {bus.m_ack_o & bus.m_err_o, !bus.m_ack_o && bus.m_dat_o != 0,
                          $countones(bus.s_stb_o) > 1}, 0);
        if (bus.m_ack_o || bus.m_err_o || fault_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_term ack %b err %b fault %b want none",
                         bus.m_ack_o, bus.m_err_o, fault_o);
            end else begin
                e = q.pop_front();
                chk("latency", samp - start, e.lat);
                chk("ack", bus.m_ack_o, !(e.fault && ERR_EN));
                chk("err", bus.m_err_o, e.fault && ERR_EN);
                chk("dat", bus.m_dat_o, e.dat);
                chk("fault", fault_o, e.fault);
                chk("fault_reg", fault_reg_o, e.rg);
                chk("stb_sel", stb_or, e.stb);
                chk("stb_cycles", stb_n, e.stbn);
            end
        end
    end

    task automatic push(exp_t e);
        q.push_back(e);
        start  = samp + 1;
        stb_or = '0;
        stb_n  = 0;
    endtask

    task automatic drive(logic [63:0] adr, logic [3:0] sp);
        bus.m_adr_i = adr;
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
        spur        = sp;
    endtask

    task automatic idle();
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        spur        = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk_i);
            #1;
            n++;
        end while (q.size() != 0 && n < 40);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done pending %0d after %0d cycles want 0", q.size(), n);
            q.delete();
        end
    endtask

    task automatic run_vec(vec_t v);
        @(posedge clk_i);
        #1;
        drive(v.adr, v.spur);
        push(v.e);
        wait_done();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    function automatic logic [26:0] outs();
        return {bus.s_stb_o, bus.m_ack_o, bus.m_err_o, bus.m_dat_o, fault_o, fault_reg_o};
    endfunction

    initial begin
        vec_t tbl [9];
        tbl[0] = '{64'h10,                  4'b0000, '{16'hBEEF, 4'b0001, 2, 2, 1'b0, 4'h0}};
        tbl[1] = '{64'hF00002,              4'b0111, '{16'h3333, 4'b1000, 3, 3, 1'b0, 4'h0}};
        tbl[2] = '{64'h500000,              4'b0000, '{16'h0000, 4'b0000, 0, 1, 1'b1, 4'h5}};
        tbl[3] = '{64'h100000,              4'b0000, '{16'h0000, 4'b0010, 8, 9, 1'b1, 4'h1}};
        tbl[4] = '{64'h200004,              4'b0000, '{16'h2222, 4'b0100, 1, 1, 1'b0, 4'h1}};
        tbl[5] = '{64'hFFFF_0000_0020_0000, 4'b0000, '{16'h2222, 4'b0100, 1, 1, 1'b0, 4'h1}};
        tbl[6] = '{64'hA00000,              4'b0000, '{16'h0000, 4'b0000, 0, 1, 1'b1, 4'hA}};
        tbl[7] = '{64'h0,                   4'b1110, '{16'hBEEF, 4'b0001, 2, 2, 1'b0, 4'hA}};
        tbl[8] = '{64'h1F00000,             4'b0000, '{16'h3333, 4'b1000, 3, 3, 1'b0, 4'hA}};
        idle();
        bus.m_adr_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_outs", outs(), 0);
        reset_ni = 1'b1;
        for (int i = 0; i < 9; i++) run_vec(tbl[i]);
        // Back-to-back: strobe held through the IDLE cycle after an ack
        @(posedge clk_i);
        #1;
        drive(64'h200000, 4'b0000);
        push('{16'h2222, 4'b0100, 1, 1, 1'b0, 4'hA});
        wait_done();
        @(posedge clk_i);
        #1;
        bus.m_adr_i = 64'h300000;
        push('{16'h0000, 4'b0000, 0, 1, 1'b1, 4'h3});
        @(negedge clk_i);
        chk("b2b_idle_stb", bus.s_stb_o, 0);
        wait_done();
        @(posedge clk_i);
        #1;
        idle();
        // Abort three cycles into WAIT, then a timeout proves the counter restarts
        @(posedge clk_i);
        #1;
        drive(64'h100000, 4'b0000);
        repeat (4) @(negedge clk_i);
        chk("abort_stb", bus.s_stb_o, 4'b0010);
        @(posedge clk_i);
        #1;
        bus.m_cyc_i = 1'b0;
        @(negedge clk_i);
        chk("abort_drop", outs(), {4'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h3});
        @(posedge clk_i);
        #1;
        idle();
        @(negedge clk_i);
        chk("abort_idle", outs(), {4'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h3});
        run_vec(tbl[3]);
        // Asynchronous reset mid-WAIT, applied away from the clock edge
        @(posedge clk_i);
        #1;
        drive(64'h100000, 4'b0000);
        repeat (3) @(negedge clk_i);
        chk("pre_reset_stb", bus.s_stb_o, 4'b0010);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("reset_mid", outs(), 0);
        idle();
        @(negedge clk_i);
        reset_ni = 1'b1;
        run_vec(tbl[0]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
